dma_bus_master: RTL
===================

Name: dma_bus_master

Overview:
- Bus-master DMA engine that sits directly beneath the ramDmaCi custom-instruction block.
- ramDmaCi supplies the transfer setup registers: bus start address, memory start address, block size, burst size and the control pulses.
- This block moves a block of 32-bit words between the shared system bus and port B of the CI's 512-word SSRAM, splitting it into bursts.
- It reports busy/error status back to ramDmaCi's status register.

Parameters:
- MEM_ADDR_WIDTH, 9, SSRAM word-address width; memory addresses wrap modulo 2^MEM_ADDR_WIDTH.
- BLOCK_WIDTH, 10, width of block_size in words.
- BURST_WIDTH, 8, width of burst_size; burst length is burst_size+1 words.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- bus_start_address  in  32  word-aligned byte address of the first bus word.
- mem_start_address  in  MEM_ADDR_WIDTH  first SSRAM word address.
- block_size  in  BLOCK_WIDTH  total words to move; 0 means no-op.
- burst_size  in  BURST_WIDTH  words per burst minus 1.
- start_read  in  1  pulse: transfer bus->SSRAM.
- start_write  in  1  pulse: transfer SSRAM->bus.
- dma_busy  out  1  high from the accepted start until completion or abort.
- dma_error  out  1  sticky error flag; cleared by the next accepted start.
- mem_address  out  MEM_ADDR_WIDTH  SSRAM port-B address.
- mem_write_enable  out  1  SSRAM port-B write strobe.
- mem_write_data  out  32  SSRAM port-B write data.
- mem_read_data  in  32  SSRAM port-B read data; 1-cycle read latency.
- request_transaction  out  1  bus request.
- transaction_granted  in  1  bus grant.
- begin_transaction_out  out  1  one-cycle transaction start.
- address_data_out  out  32  address during begin, data during a write.
- byte_enables_out  out  4  4'hF during begin, else 0.
- burst_size_out  out  8  current burst length minus 1.
- read_n_write_out  out  1  1 = read.
- end_transaction_out  out  1  one-cycle end of a write burst.
- data_valid_out  out  1  write data valid.
- address_data_in  in  32  read data.
- end_transaction_in  in  1  slave end of a read burst.
- data_valid_in  in  1  read data valid.
- busy_in  in  1  slave stall.
- error_in  in  1  slave error.

Behaviour:
- Reset: all outputs are 0; state is IDLE; internal counters are 0.
- Start acceptance:
  - A start is accepted only in IDLE.
  - Starts that arrive while busy are ignored.
  - If start_read and start_write arrive in the same cycle, start_read wins.
  - On acceptance the block latches all setup inputs and sets remaining=block_size.
  - dma_busy rises the cycle after acceptance; dma_error clears on acceptance.
- block_size=0: dma_busy pulses high for exactly 1 cycle; no bus request is made.
- States:
  - IDLE -> REQUEST on an accepted start.
  - REQUEST: request_transaction=1 until transaction_granted.
  - BEGIN (1 cycle):
    - begin_transaction_out=1, address_data_out=current bus address, byte_enables_out=4'hF.
    - burst_size_out = min(burst_size+1, remaining) - 1.
    - For writes, the first SSRAM read is issued in this cycle.
  - READ_DATA:
    - Each data_valid_in writes address_data_in into SSRAM at mem_address, then increments mem_address (wrapping).
    - end_transaction_in moves to NEXT.
  - WRITE_DATA:
    - Drives one word per cycle with data_valid_out=1.
    - If busy_in is sampled high, the same word and address are held next cycle; there is no word loss or duplication.
    - After the last burst word, end_transaction_out=1 for 1 cycle, then NEXT.
  - NEXT:
    - remaining -= burst words; bus address += 4*burst words (32-bit wrap).
    - Goes to REQUEST if remaining>0, else DONE.
    - request_transaction drops between bursts so the arbiter can rearbitrate.
  - DONE: dma_busy=0, then IDLE.
- error_in, sampled in any non-IDLE state:
  - abort: no further SSRAM writes; a pending write burst is closed with end_transaction_out=1.
  - dma_error=1, then IDLE.
- Last burst is shortened to the remaining words, so the burst count is ceil(block_size/(burst_size+1)).
- Reset mid-transfer immediately returns to IDLE and drops all bus outputs.

Optional Feature:
- Macro DMA_ENDIAN_SWAP_EN.
- When defined:
  - Every word crossing the block is byte-reversed in both directions ({b0,b1,b2,b3}).
  - The swap is purely combinational on the data paths; timing is unchanged.
- When undefined: data passes unmodified.

Test Plan:
- Read, block_size=6, burst_size=3, bus 0x1000, mem 0x010 -> two bursts of 4 and 2 words at bus 0x1000 and 0x1010; SSRAM 0x010..0x015 holds the slave words; dma_busy falls after the second end_transaction_in.
- Write, block_size=5, burst_size=7, mem 0x1FE, SSRAM preloaded 0xA0..0xA4 -> one burst with burst_size_out=4; words 0xA0..0xA4 are read from mem 0x1FE, 0x1FF, 0x000, 0x001, 0x002 (wrap).
- Write with busy_in high for 3 cycles on the 2nd word -> the 2nd word is held for 4 cycles; the slave receives exactly 5 distinct words in order.
- error_in on the 2nd read data beat, block_size=8 -> only 1 SSRAM write; dma_error=1; dma_busy=0; a new start_read clears dma_error.
- block_size=0, start_write -> no request_transaction; dma_busy high 1 cycle; start_write asserted while busy -> ignored.
- DMA_ENDIAN_SWAP_EN defined, read of 0x11223344 -> SSRAM holds 0x44332211.

Source files
------------

// File: rtl/dma_bus_master_if.sv
// System-bus signals between the DMA bus master and the arbiter/slave side.
// Names are from the master's point of view (*_out driven by master, *_in by slave).
interface dma_bus_master_if;
  logic        request_transaction;
  logic        transaction_granted;
  logic        begin_transaction_out;
  logic [31:0] address_data_out;
  logic [3:0]  byte_enables_out;
  logic [7:0]  burst_size_out;
  logic        read_n_write_out;
  logic        end_transaction_out;
  logic        data_valid_out;
  logic [31:0] address_data_in;
  logic        end_transaction_in;
  logic        data_valid_in;
  logic        busy_in;
  logic        error_in;

  modport master (
    output request_transaction, begin_transaction_out, address_data_out,
           byte_enables_out, burst_size_out, read_n_write_out,
           end_transaction_out, data_valid_out,
    input  transaction_granted, address_data_in, end_transaction_in,
           data_valid_in, busy_in, error_in
  );

  modport slave (
    input  request_transaction, begin_transaction_out, address_data_out,
           byte_enables_out, burst_size_out, read_n_write_out,
           end_transaction_out, data_valid_out,
    output transaction_granted, address_data_in, end_transaction_in,
           data_valid_in, busy_in, error_in
  );
endinterface

// File: rtl/dma_bus_master.sv
// Burst DMA between the system bus and SSRAM port B; optional byte swap via DMA_ENDIAN_SWAP_EN.
// One word per cycle in the data phase; write bursts stall on busy_in without loss, reads follow data_valid_in.
module dma_bus_master #(
  parameter int MEM_ADDR_WIDTH = 9,
  parameter int BLOCK_WIDTH    = 10,
  parameter int BURST_WIDTH    = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [31:0]               bus_start_address,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_start_address,
  input  logic [BLOCK_WIDTH-1:0]    block_size,
  input  logic [BURST_WIDTH-1:0]    burst_size,
  input  logic                      start_read,
  input  logic                      start_write,
  output logic                      dma_busy,
  output logic                      dma_error,
  output logic [MEM_ADDR_WIDTH-1:0] mem_address,
  output logic                      mem_write_enable,
  output logic [31:0]               mem_write_data,
  input  logic [31:0]               mem_read_data,
  dma_bus_master_if.master          bus
);

  localparam int CNT_WIDTH = ((BLOCK_WIDTH > BURST_WIDTH) ? BLOCK_WIDTH : BURST_WIDTH) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_BEGIN,
    ST_READ_DATA,
    ST_WRITE_DATA,
    ST_WRITE_END,
    ST_NEXT,
    ST_DONE
  } state_t;

  state_t                    state;
  logic                      is_read;
  logic                      aborting;
  logic [31:0]               bus_addr;
  logic [MEM_ADDR_WIDTH-1:0] mem_ptr;
  logic [BLOCK_WIDTH-1:0]    remaining;
  logic [BURST_WIDTH-1:0]    burst_len_q;
  logic [CNT_WIDTH-1:0]      cur_burst;
  logic [CNT_WIDTH-1:0]      beats_left;

  logic [CNT_WIDTH-1:0]      burst_full;
  logic [CNT_WIDTH-1:0]      rem_ext;
  logic [CNT_WIDTH-1:0]      burst_words;
  logic [BLOCK_WIDTH-1:0]    rem_after;
  logic                      close_write;

  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
`ifdef DMA_ENDIAN_SWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Last burst of a block is trimmed to whatever is left.
  always_comb begin
    burst_full  = CNT_WIDTH'(burst_len_q) + CNT_WIDTH'(1);
    rem_ext     = CNT_WIDTH'(remaining);
    burst_words = (burst_full < rem_ext) ? burst_full : rem_ext;
  end

  assign rem_after   = remaining - BLOCK_WIDTH'(cur_burst);
  assign close_write = (state == ST_WRITE_DATA) || ((state == ST_BEGIN) && !is_read);

  assign mem_write_enable = (state == ST_READ_DATA) && bus.data_valid_in && !bus.error_in;
  assign mem_write_data   = mem_write_enable ? swap_bytes(bus.address_data_in) : 32'd0;

  // SSRAM has one cycle of read latency: prefetch the next word unless the slave stalls,
  // in which case the current word is simply read again.
  assign mem_address = ((state == ST_WRITE_DATA) && !bus.busy_in)
                       ? mem_ptr + MEM_ADDR_WIDTH'(1) : mem_ptr;

  assign bus.address_data_out = (state == ST_BEGIN)  ? bus_addr :
                                bus.data_valid_out   ? swap_bytes(mem_read_data) : 32'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                     <= ST_IDLE;
      is_read                   <= 1'b0;
      aborting                  <= 1'b0;
      bus_addr                  <= 32'd0;
      mem_ptr                   <= '0;
      remaining                 <= '0;
      burst_len_q               <= '0;
      cur_burst                 <= '0;
      beats_left                <= '0;
      dma_busy                  <= 1'b0;
      dma_error                 <= 1'b0;
      bus.request_transaction   <= 1'b0;
      bus.begin_transaction_out <= 1'b0;
      bus.byte_enables_out      <= 4'h0;
      bus.burst_size_out        <= 8'd0;
      bus.read_n_write_out      <= 1'b0;
      bus.end_transaction_out   <= 1'b0;
      bus.data_valid_out        <= 1'b0;
    end else begin
      bus.begin_transaction_out <= 1'b0;
      bus.byte_enables_out      <= 4'h0;
      bus.end_transaction_out   <= 1'b0;

      if ((state != ST_IDLE) && bus.error_in) begin
        dma_error               <= 1'b1;
        bus.request_transaction <= 1'b0;
        bus.data_valid_out      <= 1'b0;
        bus.burst_size_out      <= 8'd0;
        bus.read_n_write_out    <= 1'b0;
        // An open write burst still needs its end marker before the bus is released.
        if (close_write) begin
          bus.end_transaction_out <= 1'b1;
          aborting                <= 1'b1;
          state                   <= ST_WRITE_END;
        end else begin
          dma_busy <= 1'b0;
          state    <= ST_IDLE;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_read || start_write) begin
              is_read     <= start_read;
              aborting    <= 1'b0;
              bus_addr    <= bus_start_address;
              mem_ptr     <= mem_start_address;
              remaining   <= block_size;
              burst_len_q <= burst_size;
              dma_error   <= 1'b0;
              dma_busy    <= 1'b1;
              if (block_size == '0) begin
                state <= ST_DONE;
              end else begin
                bus.request_transaction <= 1'b1;
                state                   <= ST_REQUEST;
              end
            end
          end

          ST_REQUEST: begin
            if (bus.transaction_granted) begin
              bus.request_transaction   <= 1'b0;
              bus.begin_transaction_out <= 1'b1;
              bus.byte_enables_out      <= 4'hF;
              bus.burst_size_out        <= 8'(burst_words - CNT_WIDTH'(1));
              bus.read_n_write_out      <= is_read;
              cur_burst                 <= burst_words;
              state                     <= ST_BEGIN;
            end
          end

          ST_BEGIN: begin
            if (is_read) begin
              state <= ST_READ_DATA;
            end else begin
              bus.data_valid_out <= 1'b1;
              beats_left         <= cur_burst;
              state              <= ST_WRITE_DATA;
            end
          end

          ST_READ_DATA: begin
            if (bus.data_valid_in) begin
              mem_ptr <= mem_ptr + MEM_ADDR_WIDTH'(1);
            end
            if (bus.end_transaction_in) begin
              state <= ST_NEXT;
            end
          end

          ST_WRITE_DATA: begin
            if (!bus.busy_in) begin
              mem_ptr <= mem_ptr + MEM_ADDR_WIDTH'(1);
              if (beats_left == CNT_WIDTH'(1)) begin
                bus.data_valid_out      <= 1'b0;
                bus.end_transaction_out <= 1'b1;
                state                   <= ST_WRITE_END;
              end else begin
                beats_left <= beats_left - CNT_WIDTH'(1);
              end
            end
          end

          ST_WRITE_END: begin
            if (aborting) begin
              dma_busy <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              state <= ST_NEXT;
            end
          end

          ST_NEXT: begin
            remaining            <= rem_after;
            bus_addr             <= bus_addr + (32'(cur_burst) << 2);
            bus.burst_size_out   <= 8'd0;
            bus.read_n_write_out <= 1'b0;
            if (rem_after != '0) begin
              bus.request_transaction <= 1'b1;
              state                   <= ST_REQUEST;
            end else begin
              state <= ST_DONE;
            end
          end

          ST_DONE: begin
            dma_busy <= 1'b0;
            state    <= ST_IDLE;
          end

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
